// File: rtl/sram_bist_ctrl.sv
// March-style BIST initiator for a single-port synchronous SRAM.
// Runs W0/R0 ascending and W1/R1 descending, then reports pass/fail and first-failure details.
module sram_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [ADDR_W+1:0]   err_count,
  output logic [ADDR_W-1:0]   first_fail_addr,
  output logic [DATA_W-1:0]   first_fail_exp,
  output logic [DATA_W-1:0]   first_fail_act,
  output logic                mem_wr_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out
);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, FIN} state_t;

  localparam logic [ADDR_W-1:0] A_MAX = '1;
  localparam logic [ADDR_W+1:0] E_MAX = '1;

  state_t              state, state_n;
  logic [DATA_W-1:0]   seed_r;
  logic                wr_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   data_n;
  logic                rd_vld;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_exp;
  logic                miscmp;
  logic [ADDR_W+1:0]   err_n;

  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    return s ^ DATA_W'(a);
  endfunction

  // State and mem_addr describe the bus cycle currently being driven;
  // the next-cycle bus values are computed here and registered below.
  always_comb begin
    state_n = state;
    wr_n    = 1'b0;
    addr_n  = '0;
    data_n  = '0;
    case (state)
      IDLE: if (start) begin
        state_n = W0;
        wr_n    = 1'b1;
        data_n  = pat(seed, '0);
      end
      W0: if (mem_addr == A_MAX) begin
        state_n = R0;
      end else begin
        wr_n   = 1'b1;
        addr_n = mem_addr + 1'b1;
        data_n = pat(seed_r, addr_n);
      end
      R0: if (mem_addr == A_MAX) begin
        state_n = W1;
        wr_n    = 1'b1;
        addr_n  = A_MAX;
        data_n  = ~pat(seed_r, A_MAX);
      end else begin
        addr_n = mem_addr + 1'b1;
      end
      W1: if (mem_addr == '0) begin
        state_n = R1;
        addr_n  = A_MAX;
      end else begin
        wr_n   = 1'b1;
        addr_n = mem_addr - 1'b1;
        data_n = ~pat(seed_r, addr_n);
      end
      R1: if (mem_addr == '0) begin
        state_n = FIN;
      end else begin
        addr_n = mem_addr - 1'b1;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    miscmp = rd_vld && (mem_data_out != rd_exp);
    err_n  = err_count;
    if (miscmp && (err_count != E_MAX)) err_n = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      seed_r          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_exp  <= '0;
      first_fail_act  <= '0;
      mem_wr_rd_en    <= 1'b0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      rd_vld          <= 1'b0;
      rd_addr         <= '0;
      rd_exp          <= '0;
    end else begin
      state        <= state_n;
      mem_wr_rd_en <= wr_n;
      mem_addr     <= addr_n;
      mem_data_in  <= data_n;
      // The SRAM captures the read at this edge; its data is compared one edge later.
      rd_vld       <= (state == R0) || (state == R1);
      rd_addr      <= mem_addr;
      rd_exp       <= (state == R0) ? pat(seed_r, mem_addr) : ~pat(seed_r, mem_addr);
      done         <= (state == FIN);
      busy         <= (state_n != IDLE) || (state == FIN);
      if (state == IDLE && start) begin
        seed_r          <= seed;
        err_count       <= '0;
        first_fail_addr <= '0;
        first_fail_exp  <= '0;
        first_fail_act  <= '0;
        pass            <= 1'b0;
        fail            <= 1'b0;
      end else begin
        err_count <= err_n;
        if (miscmp && (err_count == '0)) begin
          first_fail_addr <= rd_addr;
          first_fail_exp  <= rd_exp;
          first_fail_act  <= mem_data_out;
        end
        if (state == FIN) begin
          pass <= (err_n == '0);
          fail <= (err_n != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Scoreboard bench for sram_bist_ctrl with a behavioural SRAM that can inject faults.
module tb_sram_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic       busy, done, pass, fail;
  logic [9:0] err_count;
  logic [7:0] first_fail_addr, first_fail_exp, first_fail_act;
  logic       mem_wr_rd_en;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;

  sram_bist_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .first_fail_addr(first_fail_addr),
    .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act),
    .mem_wr_rd_en(mem_wr_rd_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 0 = good, 1 = bit0 of mem[0x10] stuck at 1, 2 = address bit7 stuck at 0.
  int         fault_mode = 0;
  logic [7:0] mem [256];
  logic [7:0] ea;
  assign ea = (fault_mode == 2) ? {1'b0, mem_addr[6:0]} : mem_addr;

  always @(posedge clk) begin
    if (mem_wr_rd_en) begin
      mem[ea]      <= (fault_mode == 1 && ea == 8'h10) ? (mem_data_in | 8'h01) : mem_data_in;
      mem_data_out <= '0;
    end else begin
      mem_data_out <= mem[ea];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lat; int pss; int fl; int err; int ffa; int ffe; int ffact;
  } res_t;
  typedef struct { int ord; int addr; int data; } wr_t;

  res_t exq[$];
  wr_t  wrq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   start_cyc = 0;
  int   wr_ord = 0;
  bit   wr_track = 1'b0;
  bit   post_done = 1'b0;
  int   last_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (post_done) begin
      chk("busy_after_done", int'(busy), 0);
      chk("pass_held", int'(pass), last_pass);
    end
    post_done = 1'b0;
    if (done) begin
      if (exq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = exq.pop_front();
        chk("latency", cyc - start_cyc, e.lat);
        chk("busy_in_done", int'(busy), 1);
        chk("pass", int'(pass), e.pss);
        chk("fail", int'(fail), e.fl);
        chk("err_count", int'(err_count), e.err);
        chk("first_fail_addr", int'(first_fail_addr), e.ffa);
        chk("first_fail_exp", int'(first_fail_exp), e.ffe);
        chk("first_fail_act", int'(first_fail_act), e.ffact);
        post_done = 1'b1;
        last_pass = int'(pass);
      end
    end
  end

  // Bus monitor: compares selected write ordinals against hand-computed values.
  always @(negedge clk) begin
    if (wr_track && mem_wr_rd_en) begin
      if (wrq.size() > 0 && wrq[0].ord == wr_ord) begin
        wr_t w;
        w = wrq.pop_front();
        chk($sformatf("bus_wr%0d_addr", w.ord), int'(mem_addr), w.addr);
        chk($sformatf("bus_wr%0d_data", w.ord), int'(mem_data_in), w.data);
      end
      wr_ord++;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_passfail"}, int'({pass, fail}), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_ff"}, int'({first_fail_addr, first_fail_exp, first_fail_act}), 0);
    chk({tag, "_bus"}, int'({mem_wr_rd_en, mem_addr, mem_data_in}), 0);
  endtask

  task automatic issue_start(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    seed  = ~s;   // mid-test seed changes must not matter
    @(negedge clk);
    chk("busy_running", int'(busy), 1);
  endtask

  task automatic run(input logic [7:0] s, input int f, input res_t e, input bit second);
    fault_mode = f;
    exq.push_back(e);
    issue_start(s);
    if (second) begin
      repeat (298) @(negedge clk);
      seed  = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && exq.size() != 0; i++) @(negedge clk);
    if (exq.size() != 0) begin
      chk("done_timeout", 0, 1);
      void'(exq.pop_front());
    end
    repeat (3) @(negedge clk);
    if (second) repeat (1100) @(negedge clk);
  endtask

  res_t good, stuck, alias_r;

  initial begin
    good    = '{lat: 1025, pss: 1, fl: 0, err: 0,   ffa: 0,     ffe: 0,     ffact: 0};
    stuck   = '{lat: 1025, pss: 0, fl: 1, err: 1,   ffa: 8'h10, ffe: 8'h10, ffact: 8'h11};
    alias_r = '{lat: 1025, pss: 0, fl: 1, err: 256, ffa: 0,     ffe: 0,     ffact: 8'h80};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    run(8'h00, 0, good, 1'b0);

    wrq.push_back('{ord: 0,   addr: 8'h00, data: 8'hA5});
    wrq.push_back('{ord: 1,   addr: 8'h01, data: 8'hA4});
    wrq.push_back('{ord: 256, addr: 8'hFF, data: 8'hA5});
    wr_ord   = 0;
    wr_track = 1'b1;
    run(8'hA5, 0, good, 1'b0);
    wr_track = 1'b0;
    if (wrq.size() != 0) begin
      chk("bus_writes_seen", wrq.size(), 0);
      wrq.delete();
    end

    run(8'h00, 1, stuck, 1'b0);
    run(8'h00, 2, alias_r, 1'b0);

    // Abort mid-R0: results cleared, no done afterwards.
    fault_mode = 0;
    issue_start(8'h5A);
    repeat (398) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (1100) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);

    run(8'h00, 0, good, 1'b0);
    run(8'h00, 2, alias_r, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", nvec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bist_ctrl.md
# sram_bist_ctrl

Built-in self-test initiator for the 8-bit-wide, 256-deep synchronous SRAM on the `sram_if` bus. On a `start` pulse it drives the SRAM's `wr_rd_en`/`addr`/`data_in` through a four-phase march sequence and checks every read against the expected value. It reports pass/fail, the error count, and details of the first failure. It sits between the test/config logic and the SRAM; the SRAM's own `reset_n` is driven elsewhere.

## Interface

Parameters:
- `ADDR_W`, 8: SRAM address width; depth `D` = 2**`ADDR_W`.
- `DATA_W`, 8: SRAM data width.

Ports:
- `clk`  in  1  rising-edge clock, shared with the SRAM.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `seed`  in  `DATA_W`  pattern seed; sampled when `start` is accepted.
- `busy`  out  1  high while a test runs.
- `done`  out  1  one-cycle pulse when a test completes.
- `pass`  out  1  last test had zero mismatches; held until next accepted start.
- `fail`  out  1  last test had at least one mismatch; held until next accepted start.
- `err_count`  out  `ADDR_W`+2  mismatch count; saturates at all-ones.
- `first_fail_addr`  out  `ADDR_W`  address of the first mismatch.
- `first_fail_exp`  out  `DATA_W`  expected data at the first mismatch.
- `first_fail_act`  out  `DATA_W`  actual data at the first mismatch.
- `mem_wr_rd_en`  out  1  to SRAM `wr_rd_en`: 1 = write, 0 = read.
- `mem_addr`  out  `ADDR_W`  to SRAM `addr`.
- `mem_data_in`  out  `DATA_W`  to SRAM `data_in`.
- `mem_data_out`  in  `DATA_W`  from SRAM `data_out`.

## Operation

- SRAM contract:
  - Write: `wr_rd_en`=1 at an edge writes `data_in` to `mem[addr]`; `data_out` goes to 0.
  - Read: `wr_rd_en`=0 at an edge loads `data_out` with `mem[addr]`.
  - Read data is therefore sampled by this block at the edge after the one that issued the read.
- Pattern: P(a) = `seed_r` XOR a, with a zero-extended/truncated to `DATA_W`. `seed_r` is registered at start.
- States: IDLE, W0, R0, W1, R1, FIN.
  - IDLE: `start`=1 → W0. Also registers `seed_r`, clears `err_count`/`first_fail_*`, and drops `pass`/`fail` to 0.
  - W0: ascending a = 0..D-1; write P(a). After a = D-1 → R0.
  - R0: ascending a = 0..D-1; read, expected P(a). After a = D-1 → W1.
  - W1: descending a = D-1..0; write ~P(a). After a = 0 → R1.
  - R1: descending a = D-1..0; read, expected ~P(a). After a = 0 → FIN.
  - FIN: single drain cycle for the last compare → IDLE. `done`=1 for one cycle and `pass`/`fail` are set.
- Compare pipeline: each read issue registers (`rd_vld`, addr, expected). At the next edge, if `rd_vld`=1 and `mem_data_out` ≠ expected, a mismatch is recorded.
  - The R0 tail compare overlaps the first W1 cycle. This is legal because `data_out` updates only at the end of that cycle.
- On a mismatch: `err_count` increments (saturating). If it is the first mismatch since start, `first_fail_*` are captured; later mismatches never overwrite them.
- Outside W0/R0/W1/R1: `mem_wr_rd_en`=0, `mem_addr`=0, `mem_data_in`=0 (idle reads of address 0 are harmless and never compared).
- `start` while not IDLE is ignored; `seed` changes mid-test have no effect.

## Timing

- All outputs are registered.
- Reset values: `busy`, `done`, `pass`, `fail`, `err_count`, `first_fail_*`, `mem_wr_rd_en`, `mem_addr`, `mem_data_in` are all 0. State goes to IDLE.
- Reset asserted mid-test aborts immediately: no `done`, results are cleared, and SRAM contents are left as-is.
- Taking edge E0 as the one where `start` is accepted:
  - W0 drives bus cycles E0–E1 … E(D-1)–E(D).
  - Writes land at E1..E(D).
  - R0 occupies edges E(D+1)..E(2D), W1 edges E(2D+1)..E(3D), R1 edges E(3D+1)..E(4D).
  - FIN compare occurs at E(4D+1); `done`/`pass`/`fail` become visible after E(4D+1).
  - With D=256, a test takes 1025 cycles.
- `busy`=1 from after E0 through the `done` cycle inclusive; it is 0 the cycle after `done`.
- One bus operation per cycle, with no bubbles between phases.

## Test plan

- Good SRAM, `seed`=0x00 → `done` exactly 1025 cycles after start; `pass`=1, `fail`=0, `err_count`=0.
- Good SRAM, `seed`=0xA5 → bus monitor sees:
  - first W0 write addr 0x00 / data 0xA5, then 0x01 / 0xA4;
  - first W1 write addr 0xFF / data 0xA5;
  - `pass`=1.
- SRAM with bit0 of `mem[0x10]` stuck at 1, `seed`=0x00:
  - `fail`=1, `err_count`=1;
  - `first_fail_addr`=0x10, `first_fail_exp`=0x10, `first_fail_act`=0x11.
- SRAM with address bit7 stuck at 0 (0x80..0xFF alias 0x00..0x7F), `seed`=0x00:
  - `err_count`=256;
  - `first_fail_addr`=0x00, `first_fail_exp`=0x00, `first_fail_act`=0x80.
- `reset` pulsed mid-R0 (cycle 400):
  - all outputs are 0 and no `done` occurs;
  - a new start with a good SRAM passes in 1025 cycles.
- Second `start` pulse at cycle 300 of a running test → ignored; exactly one `done`, at cycle 1025, with unchanged results.
